// File: rtl/move_op_handler.sv
// move_op_handler: runs one move operation in two axes. The block computes a
// target position (absolute argument, or the current position plus a relative
// argument with wrap-around), asks the motors for |target - cur| pulses in the
// sign direction, waits for them to finish (with an optional timeout), and then
// reports the new position.
//
// Ports:
//   clk, reset (async, active low), clk_en (state advances only when 1)
//   trigger, abs_mode, arg_x/arg_y, cur_x/cur_y   : operation request
//   rdy, done, err                                : handshake and status
//   motors_trigger, motors_pulse_num_x/_y,
//   motors_dir_x/_y (1 = negative), motors_done   : motor interface
//   pos_new_x/_y, pos_update                      : updated position strobe
module move_op_handler #(
  parameter int POS_X_BITS     = 12,
  parameter int POS_Y_BITS     = 12,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  trigger,
  input  logic                  abs_mode,
  input  logic [POS_X_BITS-1:0] arg_x,
  input  logic [POS_Y_BITS-1:0] arg_y,
  input  logic [POS_X_BITS-1:0] cur_x,
  input  logic [POS_Y_BITS-1:0] cur_y,
  output logic                  rdy,
  output logic                  done,
  output logic                  err,
  output logic                  motors_trigger,
  output logic [POS_X_BITS-1:0] motors_pulse_num_x,
  output logic [POS_Y_BITS-1:0] motors_pulse_num_y,
  output logic                  motors_dir_x,
  output logic                  motors_dir_y,
  input  logic                  motors_done,
  output logic [POS_X_BITS-1:0] pos_new_x,
  output logic [POS_Y_BITS-1:0] pos_new_y,
  output logic                  pos_update
);

  localparam int XW = POS_X_BITS;
  localparam int YW = POS_Y_BITS;

  // Timeout counter counts 0 .. TIMEOUT_CYCLES-1 across enabled WAIT cycles.
  localparam bit          TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int unsigned TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_DRIVE,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t state;

  // Request captured at accept time
  logic          abs_q;
  logic [XW-1:0] arg_x_q, cur_x_q;
  logic [YW-1:0] arg_y_q, cur_y_q;

  // Results registered in CALC
  logic [XW-1:0] tgt_x_q, pulse_x_q;
  logic [YW-1:0] tgt_y_q, pulse_y_q;
  logic          dir_x_q, dir_y_q;
  logic [TW-1:0] tmo_cnt;

  // Combinational move calculation from the captured request
  logic [XW-1:0] tgt_x_c, pulse_x_c;
  logic [YW-1:0] tgt_y_c, pulse_y_c;
  logic [XW:0]   delta_x_c;
  logic [YW:0]   delta_y_c;

  always_comb begin
    // Relative targets wrap naturally at the coordinate width.
    tgt_x_c   = abs_q ? arg_x_q : arg_x_q + cur_x_q;
    tgt_y_c   = abs_q ? arg_y_q : arg_y_q + cur_y_q;
    // One extra bit so the difference of two signed coordinates never overflows.
    delta_x_c = {tgt_x_c[XW-1], tgt_x_c} - {cur_x_q[XW-1], cur_x_q};
    delta_y_c = {tgt_y_c[YW-1], tgt_y_c} - {cur_y_q[YW-1], cur_y_q};
    // |delta| < 2^W, so negating only the low W bits gives the exact magnitude.
    pulse_x_c = delta_x_c[XW] ? (~delta_x_c[XW-1:0] + 1'b1) : delta_x_c[XW-1:0];
    pulse_y_c = delta_y_c[YW] ? (~delta_y_c[YW-1:0] + 1'b1) : delta_y_c[YW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      abs_q     <= 1'b0;
      arg_x_q   <= '0;
      arg_y_q   <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      tgt_x_q   <= '0;
      tgt_y_q   <= '0;
      pulse_x_q <= '0;
      pulse_y_q <= '0;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            abs_q   <= abs_mode;
            arg_x_q <= arg_x;
            arg_y_q <= arg_y;
            cur_x_q <= cur_x;
            cur_y_q <= cur_y;
            err     <= 1'b0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          tgt_x_q   <= tgt_x_c;
          tgt_y_q   <= tgt_y_c;
          pulse_x_q <= pulse_x_c;
          pulse_y_q <= pulse_y_c;
          dir_x_q   <= delta_x_c[XW];
          dir_y_q   <= delta_y_c[YW];
          // A zero move skips the motors entirely.
          if (pulse_x_c == '0 && pulse_y_c == '0) state <= S_UPDATE;
          else                                     state <= S_DRIVE;
        end
        S_DRIVE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // motors_done wins over a timeout expiring in the same cycle.
          if (motors_done) begin
            state <= S_UPDATE;
          end else if (TMO_EN && tmo_cnt == TLAST) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_UPDATE: state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign rdy                = (state == S_IDLE);
  assign motors_trigger     = (state == S_DRIVE);
  assign pos_update         = (state == S_UPDATE);
  assign done               = (state == S_DONE);
  assign motors_pulse_num_x = pulse_x_q;
  assign motors_pulse_num_y = pulse_y_q;
  assign motors_dir_x       = dir_x_q;
  assign motors_dir_y       = dir_y_q;
  assign pos_new_x          = tgt_x_q;
  assign pos_new_y          = tgt_y_q;

endmodule

// File: tb/tb_move_op_handler.sv
// Testbench for move_op_handler: stimulus pushes expected results into a
// queue; a monitor pops and compares on motors_trigger / pos_update / done.
module tb_move_op_handler;

  localparam int XW  = 12;
  localparam int YW  = 12;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_en = 1'b1;
  logic          trigger = 1'b0;
  logic          abs_mode = 1'b0;
  logic          motors_done = 1'b0;
  logic [XW-1:0] arg_x = '0, cur_x = '0;
  logic [YW-1:0] arg_y = '0, cur_y = '0;
  logic          rdy, done, err, motors_trigger, motors_dir_x, motors_dir_y, pos_update;
  logic [XW-1:0] motors_pulse_num_x, pos_new_x;
  logic [YW-1:0] motors_pulse_num_y, pos_new_y;

  move_op_handler #(
    .POS_X_BITS(XW),
    .POS_Y_BITS(YW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .trigger(trigger),
    .abs_mode(abs_mode),
    .arg_x(arg_x),
    .arg_y(arg_y),
    .cur_x(cur_x),
    .cur_y(cur_y),
    .rdy(rdy),
    .done(done),
    .err(err),
    .motors_trigger(motors_trigger),
    .motors_pulse_num_x(motors_pulse_num_x),
    .motors_pulse_num_y(motors_pulse_num_y),
    .motors_dir_x(motors_dir_x),
    .motors_dir_y(motors_dir_y),
    .motors_done(motors_done),
    .pos_new_x(pos_new_x),
    .pos_new_y(pos_new_y),
    .pos_update(pos_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none/other", name);
  endtask

  typedef struct {
    int px, py;
    bit dx, dy;
    bit mv, upd, er;
    int nx, ny;
  } exp_t;

  exp_t q[$];
  int   seen_trig = 0;
  int   seen_upd = 0;

  // Reference model: plain integer arithmetic on signed coordinates.
  function automatic int wrapw(input int v, input int w);
    int m;
    m = 1 << w;
    v = (v + m / 2) % m;
    if (v < 0) v += m;
    return v - m / 2;
  endfunction

  function automatic exp_t model(input bit am, input int ax, input int ay,
                                 input int cx, input int cy, input int d);
    exp_t e;
    int tx, ty, ddx, ddy;
    tx   = am ? ax : wrapw(cx + ax, XW);
    ty   = am ? ay : wrapw(cy + ay, YW);
    ddx  = tx - cx;
    ddy  = ty - cy;
    e.px = (ddx < 0) ? -ddx : ddx;
    e.py = (ddy < 0) ? -ddy : ddy;
    e.dx = (ddx < 0);
    e.dy = (ddy < 0);
    e.mv = (e.px != 0) || (e.py != 0);
    e.er = e.mv && (d == 0);
    e.upd = !e.er;
    e.nx = tx;
    e.ny = ty;
    return e;
  endfunction

  // Enabled-edge counter used for latency measurement.
  int en_cnt = 0;
  always @(posedge clk) if (clk_en) en_cnt <= en_cnt + 1;

  // clk_en pattern: 0 = always on, 1 = alternate, 2 = random
  int en_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = ~clk_en;
      default: clk_en = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: strobes count only on cycles where the state will advance.
  always @(negedge clk) begin
    if (reset && clk_en) begin
      if (motors_trigger) begin
        if (q.size() == 0) fail_now("unexpected_motors_trigger");
        else begin
          chk("pulse_x", int'(motors_pulse_num_x), q[0].px);
          chk("pulse_y", int'(motors_pulse_num_y), q[0].py);
          chk("dir_x", int'(motors_dir_x), int'(q[0].dx));
          chk("dir_y", int'(motors_dir_y), int'(q[0].dy));
          seen_trig++;
        end
      end
      if (pos_update) begin
        if (q.size() == 0) fail_now("unexpected_pos_update");
        else begin
          chk("pos_new_x", int'($signed(pos_new_x)), q[0].nx);
          chk("pos_new_y", int'($signed(pos_new_y)), q[0].ny);
          seen_upd++;
        end
      end
      if (done) begin
        if (q.size() == 0) fail_now("unexpected_done");
        else begin
          chk("err_at_done", int'(err), int'(q[0].er));
          chk("motors_trigger_count", seen_trig, q[0].mv ? 1 : 0);
          chk("pos_update_count", seen_upd, q[0].upd ? 1 : 0);
          void'(q.pop_front());
          seen_trig = 0;
          seen_upd = 0;
        end
      end
    end
  end

  task automatic wait_en_edge();
    do @(negedge clk); while (!clk_en);
    @(posedge clk);
    #1;
  endtask

  // Drive a request and hold trigger until an enabled edge in IDLE accepts it.
  task automatic start_op(input bit am, input int ax, input int ay, input int cx,
                          input int cy, output int a0, output bit ok);
    @(posedge clk);
    #1;
    abs_mode = am;
    arg_x = ax[XW-1:0];
    arg_y = ay[YW-1:0];
    cur_x = cx[XW-1:0];
    cur_y = cy[YW-1:0];
    trigger = 1'b1;
    ok = 1'b0;
    a0 = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (rdy && clk_en) begin
        ok = 1'b1;
        a0 = en_cnt;
        break;
      end
    end
    @(posedge clk);
    #1;
    trigger = 1'b0;
    // Inputs are junk after accept; the block must use its captured copy.
    abs_mode = 1'($urandom());
    arg_x = XW'($urandom());
    arg_y = YW'($urandom());
    cur_x = XW'($urandom());
    cur_y = YW'($urandom());
    if (!ok) fail_now("accept_wait_expired");
  endtask

  task automatic wait_motors_trigger(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (motors_trigger && clk_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("motors_trigger_wait_expired");
  endtask

  // d: WAIT cycle (1..TMO) in which motors_done is sampled; 0 = never (timeout).
  task automatic run_op(input bit am, input int ax, input int ay, input int cx,
                        input int cy, input int d, input bit busy);
    exp_t e;
    int   a0, exp_lat;
    bit   ok;
    e = model(am, ax, ay, cx, cy, d);
    q.push_back(e);
    exp_lat = !e.mv ? 2 : (d == 0 ? 2 + TMO : 3 + d);
    start_op(am, ax, ay, cx, cy, a0, ok);
    if (!ok) begin
      q.delete();
      return;
    end
    if (!e.mv) begin
      if (busy) begin
        trigger = 1'b1;
        wait_en_edge();
        trigger = 1'b0;
      end
    end else begin
      wait_motors_trigger(ok);
      if (!ok) begin
        q.delete();
        return;
      end
      @(posedge clk);
      #1;
      if (busy) trigger = 1'b1;
      if (d > 0) begin
        repeat (d - 1) wait_en_edge();
        motors_done = 1'b1;
        wait_en_edge();
        motors_done = 1'b0;
      end else begin
        wait_en_edge();
      end
      trigger = 1'b0;
    end
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("done_wait_expired");
      q.delete();
      return;
    end
    chk("done_latency", en_cnt - a0 - 1, exp_lat);
    wait_en_edge();
    chk("err_sticky_idle", int'(err), int'(e.er));
    chk("rdy_after_done", int'(rdy), 1);
  endtask

  initial begin
    bit   ok;
    int   a0;
    int   ax, ay, cx, cy, d;
    bit   am;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rdy", int'(rdy), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_motors_trigger", int'(motors_trigger), 0);
    chk("reset_pos_update", int'(pos_update), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_op(1'b0, 20, -30, 100, 50, 5, 1'b0);       // relative move
    run_op(1'b1, 7, 7, 7, 7, 0, 1'b0);             // zero absolute move
    run_op(1'b0, 15, -3, 0, 0, 0, 1'b0);           // timeout, err sticky
    run_op(1'b0, -5, 9, 10, 10, TMO, 1'b0);        // motors_done on expiry cycle
    run_op(1'b1, 2047, 0, -2048, 0, 2, 1'b0);      // full-range positive
    run_op(1'b0, 1, 0, 2047, 5, 1, 1'b0);          // relative wrap

    en_mode = 1;                                    // clk_en toggling, busy triggers
    run_op(1'b0, 3, 4, 1, 1, 2, 1'b1);
    run_op(1'b1, 5, 5, 5, 5, 0, 1'b1);
    run_op(1'b0, 0, -1, 0, 0, 0, 1'b1);

    // Reset asserted while waiting on the motors
    en_mode = 0;
    q.push_back(model(1'b0, 100, 100, 0, 0, 3));
    start_op(1'b0, 100, 100, 0, 0, a0, ok);
    if (ok) wait_motors_trigger(ok);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    seen_trig = 0;
    seen_upd = 0;
    chk("midreset_rdy", int'(rdy), 1);
    chk("midreset_motors_trigger", int'(motors_trigger), 0);
    chk("midreset_pos_update", int'(pos_update), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_err", int'(err), 0);
    chk("midreset_pulse_x", int'(motors_pulse_num_x), 0);
    chk("midreset_pulse_y", int'(motors_pulse_num_y), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    motors_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    motors_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("postreset_rdy", int'(rdy), 1);
    end

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      en_mode = $urandom_range(0, 2);
      am = 1'($urandom());
      cx = int'($urandom_range(0, 4095)) - 2048;
      cy = int'($urandom_range(0, 4095)) - 2048;
      ax = int'($urandom_range(0, 4095)) - 2048;
      ay = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 4) == 0) begin
        if (am) begin
          ax = cx;
          ay = cy;
        end else begin
          ax = 0;
          ay = 0;
        end
      end
      d = $urandom_range(0, TMO);
      run_op(am, ax, ay, cx, cy, d, 1'($urandom()));
    end

    en_mode = 0;
    repeat (5) @(negedge clk);
    chk("queue_empty_at_end", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_op_handler.md
MOVE_OP_HANDLER -- requirements
Module: move_op_handler

Interface
REQ-001 SHALL have parameter POS_X_BITS, default 12: signed X coordinate width.
REQ-002 SHALL have parameter POS_Y_BITS, default 12: signed Y coordinate width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0: WAIT timeout in enabled cycles; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clk_en, input, 1: state advances only when clk_en=1.
REQ-007 SHALL have port trigger, input, 1: operation start request.
REQ-008 SHALL have port abs_mode, input, 1: 1 selects absolute arguments, 0 selects relative arguments.
REQ-009 SHALL have ports arg_x / arg_y, input, POS_X_BITS / POS_Y_BITS: signed arguments.
REQ-010 SHALL have ports cur_x / cur_y, input, POS_X_BITS / POS_Y_BITS: signed current position.
REQ-011 SHALL have port rdy, output, 1: block is idle and will accept a trigger.
REQ-012 SHALL have port done, output, 1: one-cycle operation-complete strobe.
REQ-013 SHALL have port err, output, 1: last operation timed out.
REQ-014 SHALL have port motors_trigger, output, 1: one-cycle motor start strobe.
REQ-015 SHALL have ports motors_pulse_num_x / motors_pulse_num_y, output, POS_X_BITS / POS_Y_BITS: unsigned pulse counts.
REQ-016 SHALL have ports motors_dir_x / motors_dir_y, output, 1: 1 means negative direction.
REQ-017 SHALL have port motors_done, input, 1: motor move complete.
REQ-018 SHALL have ports pos_new_x / pos_new_y, output, POS_X_BITS / POS_Y_BITS: updated position.
REQ-019 SHALL have port pos_update, output, 1: one-cycle strobe marking pos_new_x/pos_new_y valid.

Function
REQ-020 SHALL implement states IDLE, CALC, DRIVE, WAIT, UPDATE, DONE; all transitions require clk_en=1.
REQ-021 SHALL decode rdy, motors_trigger, pos_update and done from state only: rdy=IDLE, motors_trigger=DRIVE, pos_update=UPDATE, done=DONE.
REQ-022 SHALL, in IDLE with trigger=1, latch abs_mode, arg_x/arg_y and cur_x/cur_y, clear err, and go to CALC.
REQ-023 SHALL ignore trigger in every state except IDLE.
REQ-024 SHALL, in CALC, compute target = arg if abs_mode=1, else cur+arg truncated to the coordinate width (wrap-around), per axis.
REQ-025 SHALL compute delta = target - cur per axis, sign-extended to width+1; pulse_num = |delta| (fits in width bits); dir = sign of delta.
REQ-026 SHALL register target, pulse_num and dir in CALC and hold them stable until the next accept.
REQ-027 SHALL go CALC->UPDATE when both pulse counts are 0 (motors not triggered); otherwise CALC->DRIVE.
REQ-028 SHALL go DRIVE->WAIT after exactly one enabled cycle.
REQ-029 SHALL go WAIT->UPDATE when motors_done=1 is sampled.
REQ-030 SHALL, when TIMEOUT_CYCLES>0, count enabled WAIT cycles; on reaching TIMEOUT_CYCLES without motors_done it SHALL set err=1 and go WAIT->DONE, skipping UPDATE.
REQ-031 SHALL drive pos_new = registered target during UPDATE, then go UPDATE->DONE.
REQ-032 SHALL go DONE->IDLE after one enabled cycle.
REQ-033 SHALL keep err sticky until the next accepted trigger.
REQ-034 SHALL, for a zero move with clk_en held at 1, assert done in the third cycle after the accept edge (CALC, UPDATE, DONE).
REQ-035 SHALL give motors_done priority over the timeout when both occur in the same cycle.

Reset
REQ-036 SHALL, on reset=0 at any time including mid-operation, force IDLE and clear err, pulse/dir/target registers and the timeout counter.
REQ-037 SHALL hold rdy=1 and motors_trigger, pos_update, done and err at 0 while reset=0.

Verification
REQ-038 SHALL cover: reset asserted during WAIT -> IDLE, rdy=1, all strobes 0, motors_done afterwards ignored.
REQ-039 SHALL cover: relative move, cur=(100,50), arg=(20,-30) -> pulses (20,30), dir_x=0, dir_y=1; motors_done 5 cycles later -> pos_new=(120,20), single-cycle done.
REQ-040 SHALL cover: absolute move, cur=(7,7), arg=(7,7) -> no motors_trigger, pos_update with (7,7), done 3 cycles after accept.
REQ-041 SHALL cover: TIMEOUT_CYCLES=8 with motors_done held 0 -> err=1 and done after 8 WAIT cycles, no pos_update.
REQ-042 SHALL cover: clk_en toggling 1/0 with trigger pulsed while busy -> state advances only on enabled cycles; the busy trigger is ignored.
REQ-043 SHALL cover: width 12, absolute move, cur_x=-2048, arg_x=2047 -> pulse_x=4095, dir_x=0; relative move cur_x=2047, arg_x=1 -> target -2048, pulse_x=4095, dir_x=1.
